bcd_counter_mod6: RTL and testbench
===================================

// Module: bcd_counter_mod6
// PURPOSE
//   Single-digit BCD down-counter, modulus 6 (digit range 0..5): the tens-of-seconds digit of the timer.
//   Loadable, enable-gated and clearable. Cascades with neighbouring digits via tc (borrow out)
//   and reports when the digit reads zero.
// PARAMETERS
//   MAX_VAL   5   largest digit value; wrap target on borrow; fixed at 5 for mod-6 use
//   W         4   digit width in bits (BCD nibble)
// PORTS
//   clk    in   1   rising-edge clock; single clock domain
//   clr    in   1   asynchronous, active-high reset/clear; forces out=0
//   loadn  in   1   synchronous parallel load, active-low
//   en     in   1   count enable, active-high (one decrement per enabled clk edge)
//   data   in   4   load value, BCD
//   out    out  4   current digit, registered
//   tc     out  1   terminal count / borrow out: en & (out==0), combinational
//   zero   out  1   out==0, combinational
// BEHAVIOUR
//   - Reset: clr=1 -> out=4'd0 immediately, asynchronously, regardless of clk/loadn/en.
//     Hence zero=1 and tc=en during reset. Deasserting clr mid-operation resumes from 0 on the next edge.
//   - Priority at each rising clk edge with clr=0: loadn=0 > en=1 > hold.
//   - Load: loadn=0 -> out<=data (0..5) on the edge; en is ignored in that cycle.
//   - Count: loadn=1, en=1 -> out<=out-1 for out in 1..5; out==0 -> out<=MAX_VAL (5) (wrap/borrow).
//   - Hold: loadn=1, en=0 -> out unchanged.
//   - tc high in exactly the cycle where the digit is 0 and enabled: 1-cycle pulse per wrap for
//     continuous en. Drives the next-higher digit's en.
//   - zero = (out==4'd0) independent of en; feeds the timer's done detection.
//   - out never leaves 0..5 under any input sequence (see CONFIGURATION for illegal load data).
//   - Latency: load/count visible on out one edge later; tc/zero follow out combinationally.
// CONFIGURATION
//   BCD_MOD6_LOAD_CLAMP_EN defined:
//     - data in 6..15 with loadn=0 loads MAX_VAL (5).
//   BCD_MOD6_LOAD_CLAMP_EN undefined:
//     - data in 6..15 with loadn=0 is rejected: out holds its value and en is ignored that cycle.
//   - Legal data 0..5 behaves identically in both builds.
// STRUCTURE
//   - Shared package bcd_timer_pkg:
//     - constants BCD_W=4, MOD6_MAX=4'd5, BCD_ZERO=4'd0
//     - typedef bcd_digit_t (logic [3:0])
//   - Optional sub-module bcd_mod6_next:
//     - purely combinational next-state block (out, data, loadn, en) -> next out
//   - Top level holds the single register with async clear, plus the tc/zero decode.
// TESTING
//   1. clr=1, en=0, loadn=1 for several cycles -> out=0, zero=1, tc=0.
//      Raise en while clr=1 -> tc=1, out stays 0.
//   2. clr=0, loadn=0, data=4 for one edge -> out=4.
//      Then en=1 for 3 edges -> out 3,2,1; en=0 -> out holds 1.
//   3. Load 5, en=1 continuously for 7 edges -> out 4,3,2,1,0,5,4.
//      tc=1 only while out=0; zero=1 only while out=0.
//   4. out=3, assert clr between clk edges -> out=0 before the next edge.
//      Release clr with en=1 -> next edge out=5, tc pulsed in the prior cycle.
//   5. loadn=0 and en=1 on the same edge with data=2 -> out=2 (load wins).
//      Then loadn=1, data=0 loaded while en=1 -> tc=1.
//   6. loadn=0, data=9 -> out=5 with BCD_MOD6_LOAD_CLAMP_EN, unchanged without.
//      Assert out<=5 every cycle in both builds.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared constants and types for the BCD timer digits.
package bcd_timer_pkg;

   localparam int         BCD_W    = 4;
   localparam logic [3:0] MOD6_MAX = 4'd5;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_mod6_next.sv
// Combinational next-digit logic for the mod-6 BCD down-counter: load > count > hold.
// Illegal load data (above MAX_VAL) is rejected unless BCD_MOD6_LOAD_CLAMP_EN is defined, which clamps it to MAX_VAL.
module bcd_mod6_next
   import bcd_timer_pkg::*;
#(
   parameter int MAX_VAL = 5,
   parameter int W       = BCD_W
) (
   input  logic [W-1:0] cur,
   input  logic [W-1:0] data,
   input  logic         loadn,
   input  logic         en,
   output logic [W-1:0] nxt
);

   localparam logic [W-1:0] MAX_V  = W'(MAX_VAL);
   localparam logic [W-1:0] ZERO_V = '0;

   always_comb begin
      nxt = cur;
      if (!loadn) begin
         // A rejected load still owns the cycle, so en is ignored either way.
         if (data <= MAX_V) begin
            nxt = data;
         end
`ifdef BCD_MOD6_LOAD_CLAMP_EN
         else begin
            nxt = MAX_V;
         end
`endif
      end else if (en) begin
         if (cur == ZERO_V || cur > MAX_V) begin
            nxt = MAX_V;
         end else begin
            nxt = cur - W'(1);
         end
      end
   end

endmodule

// File: rtl/bcd_counter_mod6.sv
// Tens-of-seconds BCD down-counter digit (0..5) with async clear, borrow out (tc) and zero flag.
// Optional macro BCD_MOD6_LOAD_CLAMP_EN: illegal load data clamps to MAX_VAL instead of being rejected.
module bcd_counter_mod6
   import bcd_timer_pkg::*;
#(
   parameter int MAX_VAL = 5,
   parameter int W       = BCD_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         loadn,
   input  logic         en,
   input  logic [W-1:0] data,
   output logic [W-1:0] out,
   output logic         tc,
   output logic         zero
);

   logic [W-1:0] nxt;

   bcd_mod6_next #(
      .MAX_VAL(MAX_VAL),
      .W      (W)
   ) u_next (
      .cur  (out),
      .data (data),
      .loadn(loadn),
      .en   (en),
      .nxt  (nxt)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         out <= '0;
      end else begin
         out <= nxt;
      end
   end

   // tc drives the next-higher digit's enable: one pulse per wrap under continuous en.
   assign zero = (out == '0);
   assign tc   = en & zero;

endmodule

// File: tb/tb_bcd_counter_mod6.sv
// Directed self-checking bench for bcd_counter_mod6 (clear, load, count, wrap, priority, illegal load).
module tb_bcd_counter_mod6;

   logic       clk = 1'b0;
   logic       clr;
   logic       loadn;
   logic       en;
   logic [3:0] data;
   logic [3:0] out;
   logic       tc;
   logic       zero;

   int         errors = 0;
   int         checks = 0;
   logic       mon_on = 1'b0;
   logic [3:0] exp_q[$];

   bcd_counter_mod6 dut (
      .clk  (clk),
      .clr  (clr),
      .loadn(loadn),
      .en   (en),
      .data (data),
      .out  (out),
      .tc   (tc),
      .zero (zero)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out_q(input string tag);
      logic [3:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: expected queue empty, got %0d", tag, out);
      end else begin
         e = exp_q.pop_front();
         check(tag, out, e);
      end
   endtask

   // digit must stay within 0..5 on every cycle once out of reset
   always @(negedge clk) begin
      if (mon_on) check("range", {3'b000, (out <= 4'd5)}, 4'd1);
   end

   initial begin
      logic [3:0] seq  [7];
      logic [3:0] prev [7];
      seq  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5, 4'd4};
      prev = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};

      // reset block
      clr = 1'b1; loadn = 1'b1; en = 1'b0; data = 4'd0;
      repeat (3) tick();
      check("rst_out", out, 4'd0);
      check("rst_zero", 4'(zero), 4'd1);
      check("rst_tc", 4'(tc), 4'd0);
      en = 1'b1;
      #1;
      check("rst_tc_en", 4'(tc), 4'd1);
      tick();
      check("rst_out_en", out, 4'd0);
      mon_on = 1'b1;

      // load 4, count 3 edges, hold
      en = 1'b0; clr = 1'b0; loadn = 1'b0; data = 4'd4;
      tick();
      check("load4", out, 4'd4);
      loadn = 1'b1; en = 1'b1;
      exp_q.push_back(4'd3); exp_q.push_back(4'd2); exp_q.push_back(4'd1);
      repeat (3) begin
         tick();
         check_out_q("count");
      end
      en = 1'b0;
      tick();
      check("hold1", out, 4'd1);
      tick();
      check("hold2", out, 4'd1);

      // load 5, count through wrap
      loadn = 1'b0; data = 4'd5;
      tick();
      check("load5", out, 4'd5);
      loadn = 1'b1; en = 1'b1;
      for (int k = 0; k < 7; k++) exp_q.push_back(seq[k]);
      for (int k = 0; k < 7; k++) begin
         check("wrap_tc", 4'(tc), 4'(prev[k] == 4'd0));
         check("wrap_zero", 4'(zero), 4'(prev[k] == 4'd0));
         tick();
         check_out_q("wrap_out");
      end

      // async clear between edges from out=3
      tick();
      check("pre_clr", out, 4'd3);
      en = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      check("async_clr", out, 4'd0);
      check("async_zero", 4'(zero), 4'd1);
      en = 1'b1;
      #1;
      check("clr_tc", 4'(tc), 4'd1);
      clr = 1'b0;
      #1;
      check("rel_tc", 4'(tc), 4'd1);
      tick();
      check("rel_wrap", out, 4'd5);
      check("rel_tc_after", 4'(tc), 4'd0);

      // load beats enable; load 0 with en gives tc
      loadn = 1'b0; en = 1'b1; data = 4'd2;
      tick();
      check("load_wins", out, 4'd2);
      data = 4'd0;
      tick();
      check("load0", out, 4'd0);
      loadn = 1'b1;
      #1;
      check("load0_tc", 4'(tc), 4'd1);
      check("load0_zero", 4'(zero), 4'd1);
      tick();
      check("load0_wrap", out, 4'd5);

      // illegal load data
      loadn = 1'b0; en = 1'b0; data = 4'd3;
      tick();
      check("load3", out, 4'd3);
      data = 4'd9; en = 1'b1;
      tick();
`ifdef BCD_MOD6_LOAD_CLAMP_EN
      check("illegal9", out, 4'd5);
`else
      check("illegal9", out, 4'd3);
`endif
      data = 4'd4; en = 1'b0;
      tick();
      check("load4b", out, 4'd4);
      data = 4'd15; en = 1'b1;
      tick();
`ifdef BCD_MOD6_LOAD_CLAMP_EN
      check("illegal15", out, 4'd5);
`else
      check("illegal15", out, 4'd4);
`endif
      loadn = 1'b1; en = 1'b0; data = 4'd0;
      tick();
`ifdef BCD_MOD6_LOAD_CLAMP_EN
      check("hold_after", out, 4'd5);
`else
      check("hold_after", out, 4'd4);
`endif
      check("hold_tc", 4'(tc), 4'd0);

      // final report
      mon_on = 1'b0;
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
